// File: rtl/sum_pkg.sv
// Shared constants, FSM state type and unsigned max/min helpers for the sum window block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sum_pkg;

  localparam int SUM_W = 5;
  localparam int LEN_W = 4;
  // 2^LEN_W samples of (2^SUM_W - 1) fit in SUM_W + LEN_W bits, so the total never wraps.
  localparam int ACC_W = SUM_W + LEN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Ties return the current value (a), so a repeated extreme leaves the tracker unchanged.
  function automatic logic [SUM_W-1:0] umax(input logic [SUM_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic [SUM_W-1:0] umin(input logic [SUM_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/minmax_track.sv
// Registered running maximum and minimum of an unsigned sample stream.
// Latency: 1 cycle from load/update to the new extremes on max_q/min_q.
// Backpressure: none; the caller gates load/update with its accept strobe.
module minmax_track
  import sum_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             update,
  input  logic [SUM_W-1:0] din,
  output logic [SUM_W-1:0] max_q,
  output logic [SUM_W-1:0] min_q
);

  // Load seeds both extremes with the first sample; update folds later samples in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      min_q <= '0;
    end else if (load) begin
      max_q <= din;
      min_q <= din;
    end else if (update) begin
      max_q <= umax(max_q, din);
      min_q <= umin(min_q, din);
    end
  end

endmodule

// File: rtl/sum_window_accum.sv
// Collects a window of 1..2^LEN_W sum samples and reports total, max and min per window.
// Latency: result valid on the edge accepting the last sample; at least one HOLD cycle per window.
// Backpressure: in_ready is low while a result is held; result held until out_ready.
module sum_window_accum #(
  parameter int SUM_W = sum_pkg::SUM_W,
  parameter int LEN_W = sum_pkg::LEN_W,
  parameter int ACC_W = SUM_W + LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] in_sum,
  output logic             in_ready,
  input  logic [LEN_W-1:0] win_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [SUM_W-1:0] out_max,
  output logic [SUM_W-1:0] out_min,
  output logic             busy
);

  import sum_pkg::*;

  state_t           state_q;
  state_t           state_d;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept;
  logic             first_acc;
  logic             next_acc;

  // in_ready depends only on state and ena, never on the incoming sample.
  assign in_ready  = ena && (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign first_acc = accept && (state_q == IDLE);
  assign next_acc  = accept && (state_q == ACCUM);
  assign cnt_inc   = cnt_q + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: windows advance only on accepted samples; HOLD drains on out_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (win_len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        // len_q was captured at the first sample, so late win_len changes are ignored.
        if (accept && (cnt_inc == len_q)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Running total, sample counter and captured window length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (first_acc) begin
      acc_q <= ACC_W'(in_sum);
      cnt_q <= '0;
      len_q <= win_len;
    end else if (next_acc) begin
      acc_q <= acc_q + ACC_W'(in_sum);
      cnt_q <= cnt_inc;
    end
  end

  minmax_track u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (first_acc),
    .update (next_acc),
    .din    (in_sum),
    .max_q  (out_max),
    .min_q  (out_min)
  );

  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_total = acc_q;

endmodule

// File: doc/sum_window_accum.md
# sum_window_accum

Downstream consumer of the registered 5-bit adder sum. Collects a window of 1–16 sum samples over a valid/ready handshake and produces, per window:
- the running total,
- the maximum sample,
- the minimum sample.

Results are held until the consumer accepts them. It sits between the adder stage and the pin-output mux of the Tiny Tapeout top level.

## Interface
Parameters:
- SUM_W, 5, width of one incoming sum sample
- LEN_W, 4, width of window-length field; window holds win_len+1 samples (1..2^LEN_W)
- ACC_W, SUM_W+LEN_W (9), total width; 16×31=496 fits, so no overflow is possible

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  design enable; low blocks sample acceptance only
- in_valid  in  1  sample present on in_sum
- in_sum  in  SUM_W  unsigned sample
- in_ready  out  1  block accepts sample this cycle
- win_len  in  LEN_W  window length minus one, sampled at first sample of a window
- out_valid  out  1  result registers hold a completed window
- out_ready  in  1  consumer accepts result
- out_total  out  ACC_W  sum of window samples
- out_max  out  SUM_W  largest sample in window
- out_min  out  SUM_W  smallest sample in window
- busy  out  1  window in progress or result pending (state != IDLE)

## Operation
- Accept = in_valid && in_ready.
- States are IDLE, ACCUM and HOLD. Reset enters IDLE.
- in_ready = ena && (state != HOLD), combinational from state.
- IDLE, on accept:
  - acc=in_sum, max=min=in_sum, cnt=0, len=win_len.
  - Next state is HOLD if win_len==0, else ACCUM.
- ACCUM, on accept:
  - acc+=in_sum; max=max(max,in_sum); min=min(min,in_sum); cnt++.
  - When cnt+1==len, next state is HOLD. Otherwise stay in ACCUM.
- HOLD:
  - out_valid=1; out_total/out_max/out_min are stable.
  - On out_ready, go to IDLE. No sample is accepted in this cycle (in_ready=0 in HOLD).
- Comparisons are unsigned; ties leave max/min unchanged.
- win_len changes after the first sample of a window are ignored until the next window.
- ena low: no accepts and no state advance in IDLE/ACCUM. A pending HOLD result can still be drained by out_ready.
- out_ready while not in HOLD is ignored.

## Timing
- Reset (async assert, sync-to-clk deassert handled at top level):
  - state=IDLE; acc, cnt, len, max, min = 0.
  - out_valid=0, out_total=0, out_max=0, out_min=0, busy=0.
  - in_ready=ena.
- Latency: out_valid rises on the clock edge that accepts the final window sample. It is visible the cycle after that accept.
- Single-sample window (win_len=0): accept at edge N, out_valid high from N.
- Throughput: a window of L samples at full rate takes L accept cycles plus 1 HOLD cycle minimum. Back-to-back windows therefore have one idle input cycle.
- out_valid drops on the edge where out_ready is sampled high in HOLD. in_ready rises combinationally in that following cycle.
- Reset mid-window or mid-HOLD: partial or pending result is discarded and all outputs return to reset values immediately (asynchronous).
- No combinational path from in_valid/in_sum to any output. in_ready depends only on state and ena.

## Structure
- Shared package sum_pkg holds:
  - SUM_W, LEN_W, ACC_W constants;
  - state enum (IDLE, ACCUM, HOLD);
  - a helper function for unsigned max/min.
- One natural sub-module, minmax_track: registered running max/min with load/update enables. Accumulator, counter and FSM stay in sum_window_accum.

## Test plan
- Reset, then win_len=3 with samples 5, 17, 0, 31 at full rate:
  - out_total=53, out_max=31, out_min=0;
  - out_valid one cycle after 4th accept;
  - busy high throughout.
- win_len=0, sample 9 → out_total=9, max=min=9. With out_ready held low 5 cycles, outputs stay stable and in_ready stays 0.
- win_len=15, sixteen samples of 31 → out_total=496, no wrap. Change win_len to 1 mid-window → window still closes after 16 samples.
- in_valid toggled randomly and ena dropped for 3 cycles mid-window, samples 1, 2, 3 (win_len=2) → out_total=6. No accepts while ena=0.
- Assert rst_n low after 2 of 4 samples → out_valid=0, out_total=0, state IDLE. A fresh window 4, 4, 4, 4 then gives out_total=16.
- Back-to-back windows with out_ready tied high → second window accepted starting the cycle after HOLD. Both results are correct and none is lost.
